// File: rtl/lake_pkg.sv
// Shared constants and types for the execute-stage issue block.
package lake_pkg;

    // ALU operation codes
    localparam logic [3:0] AluAdd  = 4'd0;
    localparam logic [3:0] AluSub  = 4'd1;
    localparam logic [3:0] AluSll  = 4'd2;
    localparam logic [3:0] AluSlt  = 4'd3;
    localparam logic [3:0] AluSltu = 4'd4;
    localparam logic [3:0] AluXor  = 4'd5;
    localparam logic [3:0] AluSrl  = 4'd6;
    localparam logic [3:0] AluSra  = 4'd7;
    localparam logic [3:0] AluOr   = 4'd8;
    localparam logic [3:0] AluAnd  = 4'd9;

    // RV32I major opcodes
    localparam logic [6:0] OpcOp     = 7'b0110011;
    localparam logic [6:0] OpcOpImm  = 7'b0010011;
    localparam logic [6:0] OpcLui    = 7'b0110111;
    localparam logic [6:0] OpcAuipc  = 7'b0010111;
    localparam logic [6:0] OpcJal    = 7'b1101111;
    localparam logic [6:0] OpcJalr   = 7'b1100111;
    localparam logic [6:0] OpcBranch = 7'b1100011;

    // Branch funct3 encodings
    localparam logic [2:0] F3Beq  = 3'b000;
    localparam logic [2:0] F3Bne  = 3'b001;
    localparam logic [2:0] F3Blt  = 3'b100;
    localparam logic [2:0] F3Bge  = 3'b101;
    localparam logic [2:0] F3Bltu = 3'b110;
    localparam logic [2:0] F3Bgeu = 3'b111;

    typedef enum logic [1:0] {ASelZero, ASelRs1, ASelPc} a_sel_e;
    typedef enum logic [1:0] {BSelZero, BSelRs2, BSelImm, BSelFour} b_sel_e;
    typedef enum logic [1:0] {BrNone, BrJal, BrJalr, BrCond} br_kind_e;

    typedef struct packed {
        logic [3:0] alu_op;
        a_sel_e     sel_a;
        b_sel_e     sel_b;
        logic       wr_rd;
        br_kind_e   br_kind;
        logic       cond_zf;   // condition source: 1 = zero flag, 0 = result bit 0
        logic       cond_inv;  // invert the condition (BNE/BGE/BGEU)
        logic       illegal;
    } dec_t;

    // Register/immediate arithmetic: SUB only exists in the register form.
    function automatic logic [3:0] arith_op(input logic [2:0] f3, input logic b5,
                                            input logic is_reg);
        logic [3:0] op;
        case (f3)
            3'b000:  op = (b5 && is_reg) ? AluSub : AluAdd;
            3'b001:  op = AluSll;
            3'b010:  op = AluSlt;
            3'b011:  op = AluSltu;
            3'b100:  op = AluXor;
            3'b101:  op = b5 ? AluSra : AluSrl;
            3'b110:  op = AluOr;
            default: op = AluAnd;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/alu_issue_if.sv
// Issue-block bus: upstream handshake, ALU drive/return, writeback/redirect.
interface alu_issue_if;
    logic        i_valid;
    logic        o_ready;
    logic [6:0]  i_opcode;
    logic [2:0]  i_funct3;
    logic        i_funct7b5;
    logic [4:0]  i_rd;
    logic [31:0] i_rs1_val;
    logic [31:0] i_rs2_val;
    logic [31:0] i_imm;
    logic [31:0] i_pc;
    logic [31:0] o_alu_op_a;
    logic [31:0] o_alu_op_b;
    logic [3:0]  o_alu_op;
    logic [31:0] i_alu_res;
    logic        i_alu_zf;
    logic        o_valid;
    logic        i_ready;
    logic [4:0]  o_rd_addr;
    logic [31:0] o_rd_data;
    logic        o_rd_we;
    logic        o_br_taken;
    logic [31:0] o_br_target;
    logic        o_illegal;

    // Issue block side
    modport master (
        input  i_valid, i_opcode, i_funct3, i_funct7b5, i_rd, i_rs1_val, i_rs2_val,
               i_imm, i_pc, i_alu_res, i_alu_zf, i_ready,
        output o_ready, o_alu_op_a, o_alu_op_b, o_alu_op, o_valid, o_rd_addr,
               o_rd_data, o_rd_we, o_br_taken, o_br_target, o_illegal
    );

    // Environment side (decode, ALU, writeback)
    modport slave (
        output i_valid, i_opcode, i_funct3, i_funct7b5, i_rd, i_rs1_val, i_rs2_val,
               i_imm, i_pc, i_alu_res, i_alu_zf, i_ready,
        input  o_ready, o_alu_op_a, o_alu_op_b, o_alu_op, o_valid, o_rd_addr,
               o_rd_data, o_rd_we, o_br_taken, o_br_target, o_illegal
    );
endinterface

// File: rtl/alu_issue_dec.sv
// Combinational instruction decode for the issue block.
// ALU_ISSUE_BRANCH_EN: when defined, JAL/JALR/BRANCH are decoded; otherwise illegal.
module alu_issue_dec
    import lake_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    output dec_t       dec
);

    // Map opcode/funct fields to ALU op, operand selects, writeback and branch kind.
    always_comb begin
        dec.alu_op   = AluAdd;
        dec.sel_a    = ASelZero;
        dec.sel_b    = BSelZero;
        dec.wr_rd    = 1'b0;
        dec.br_kind  = BrNone;
        dec.cond_zf  = 1'b0;
        dec.cond_inv = 1'b0;
        dec.illegal  = 1'b0;
        case (opcode)
            OpcOp: begin
                dec.alu_op = arith_op(funct3, funct7b5, 1'b1);
                dec.sel_a  = ASelRs1;
                dec.sel_b  = BSelRs2;
                dec.wr_rd  = 1'b1;
            end
            OpcOpImm: begin
                dec.alu_op = arith_op(funct3, funct7b5, 1'b0);
                dec.sel_a  = ASelRs1;
                dec.sel_b  = BSelImm;
                dec.wr_rd  = 1'b1;
            end
            OpcLui: begin
                dec.sel_b = BSelImm;
                dec.wr_rd = 1'b1;
            end
            OpcAuipc: begin
                dec.sel_a = ASelPc;
                dec.sel_b = BSelImm;
                dec.wr_rd = 1'b1;
            end
`ifdef ALU_ISSUE_BRANCH_EN
            OpcJal, OpcJalr: begin
                // Link value pc+4 goes through the ALU; target has its own adder.
                dec.sel_a   = ASelPc;
                dec.sel_b   = BSelFour;
                dec.wr_rd   = 1'b1;
                dec.br_kind = (opcode == OpcJal) ? BrJal : BrJalr;
            end
            OpcBranch: begin
                dec.sel_a    = ASelRs1;
                dec.sel_b    = BSelRs2;
                dec.br_kind  = BrCond;
                dec.cond_inv = funct3[0];
                case (funct3)
                    F3Beq, F3Bne: begin
                        dec.alu_op  = AluSub;
                        dec.cond_zf = 1'b1;
                    end
                    F3Blt, F3Bge:   dec.alu_op = AluSlt;
                    F3Bltu, F3Bgeu: dec.alu_op = AluSltu;
                    default: begin
                        dec.sel_a    = ASelZero;
                        dec.sel_b    = BSelZero;
                        dec.br_kind  = BrNone;
                        dec.cond_inv = 1'b0;
                        dec.illegal  = 1'b1;
                    end
                endcase
            end
`endif
            default: dec.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_issue.sv
// Execute-stage issue/retire: drives the ALU from decoded fields and holds the
// result in a one-entry output buffer for writeback.
// ALU_ISSUE_BRANCH_EN: when defined, jumps/branches resolve; otherwise redirect is tied 0.
module alu_issue
    import lake_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    alu_issue_if.master bus
);

    dec_t        dec;
    logic        accept;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        rd_we_d;
    logic        br_taken_d;
    logic [31:0] br_target_d;

    logic        valid_q;
    logic [4:0]  rd_addr_q;
    logic [31:0] rd_data_q;
    logic        rd_we_q;
    logic        br_taken_q;
    logic [31:0] br_target_q;
    logic        illegal_q;

    alu_issue_dec u_dec (
        .opcode   (bus.i_opcode),
        .funct3   (bus.i_funct3),
        .funct7b5 (bus.i_funct7b5),
        .dec      (dec)
    );

    // ALU operand selection
    always_comb begin
        case (dec.sel_a)
            ASelRs1: op_a = bus.i_rs1_val;
            ASelPc:  op_a = bus.i_pc;
            default: op_a = '0;
        endcase
        case (dec.sel_b)
            BSelRs2:  op_b = bus.i_rs2_val;
            BSelImm:  op_b = bus.i_imm;
            BSelFour: op_b = 32'd4;
            default:  op_b = '0;
        endcase
    end

`ifdef ALU_ISSUE_BRANCH_EN
    logic [31:0] jalr_sum;

    // Branch resolution and redirect target
    always_comb begin
        jalr_sum = bus.i_rs1_val + bus.i_imm;
        case (dec.br_kind)
            BrJal, BrJalr: br_taken_d = 1'b1;
            BrCond: br_taken_d = (dec.cond_zf ? bus.i_alu_zf : bus.i_alu_res[0]) ^ dec.cond_inv;
            default: br_taken_d = 1'b0;
        endcase
        br_target_d = (dec.br_kind == BrJalr) ? {jalr_sum[31:1], 1'b0} : bus.i_pc + bus.i_imm;
    end
`else
    logic unused_br;

    assign br_taken_d  = 1'b0;
    assign br_target_d = '0;
    assign unused_br   = ^{dec.br_kind, dec.cond_zf, dec.cond_inv, bus.i_alu_zf};
`endif

    assign rd_we_d        = dec.wr_rd && !dec.illegal && (bus.i_rd != 5'd0);
    assign accept         = bus.i_valid && bus.o_ready;

    assign bus.o_ready    = !valid_q || bus.i_ready;
    assign bus.o_alu_op_a = op_a;
    assign bus.o_alu_op_b = op_b;
    assign bus.o_alu_op   = dec.alu_op;

    // Output buffer: load on accept, empty when writeback drains without a refill.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            valid_q     <= 1'b0;
            rd_addr_q   <= '0;
            rd_data_q   <= '0;
            rd_we_q     <= 1'b0;
            br_taken_q  <= 1'b0;
            br_target_q <= '0;
            illegal_q   <= 1'b0;
        end else if (accept) begin
            valid_q     <= 1'b1;
            rd_addr_q   <= bus.i_rd;
            rd_data_q   <= bus.i_alu_res;
            rd_we_q     <= rd_we_d;
            br_taken_q  <= br_taken_d;
            br_target_q <= br_target_d;
            illegal_q   <= dec.illegal;
        end else if (bus.i_ready) begin
            valid_q     <= 1'b0;
        end
    end

    assign bus.o_valid     = valid_q;
    assign bus.o_rd_addr   = rd_addr_q;
    assign bus.o_rd_data   = rd_data_q;
    assign bus.o_rd_we     = rd_we_q;
    assign bus.o_br_taken  = br_taken_q;
    assign bus.o_br_target = br_target_q;
    assign bus.o_illegal   = illegal_q;

endmodule

// File: tb/tb_alu_issue.sv
// Scoreboard bench for alu_issue: instruction-level reference model, randomized
// stimulus and backpressure, plus directed reset/hold scenarios.
module tb_alu_issue;

    typedef struct packed {
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic        b5;
        logic [4:0]  rd;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [31:0] pc;
    } instr_t;

    typedef struct packed {
        logic [4:0]  rd_addr;
        logic [31:0] rd_data;
        logic        rd_we;
        logic        taken;
        logic [31:0] target;
        logic        chk_target;
        logic        illegal;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic rdy_rand;
    logic [31:0] alu_r;
    exp_t exp_q[$];
    exp_t mon_e;
    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    alu_issue_if bus ();

    alu_issue u_dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    // Environment ALU answering the DUT's operand/op drive
    always_comb begin
        case (bus.o_alu_op)
            4'd0:    alu_r = bus.o_alu_op_a + bus.o_alu_op_b;
            4'd1:    alu_r = bus.o_alu_op_a - bus.o_alu_op_b;
            4'd2:    alu_r = bus.o_alu_op_a << bus.o_alu_op_b[4:0];
            4'd3:    alu_r = {31'd0, $signed(bus.o_alu_op_a) < $signed(bus.o_alu_op_b)};
            4'd4:    alu_r = {31'd0, bus.o_alu_op_a < bus.o_alu_op_b};
            4'd5:    alu_r = bus.o_alu_op_a ^ bus.o_alu_op_b;
            4'd6:    alu_r = bus.o_alu_op_a >> bus.o_alu_op_b[4:0];
            4'd7:    alu_r = $signed(bus.o_alu_op_a) >>> bus.o_alu_op_b[4:0];
            4'd8:    alu_r = bus.o_alu_op_a | bus.o_alu_op_b;
            4'd9:    alu_r = bus.o_alu_op_a & bus.o_alu_op_b;
            default: alu_r = 32'hDEAD_BEEF;
        endcase
    end
    assign bus.i_alu_res = alu_r;
    assign bus.i_alu_zf  = (alu_r == 32'd0);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    endtask

    // RV32I arithmetic semantics for register and immediate forms
    function automatic logic [31:0] arith(input logic [2:0] f3, input logic b5,
                                          input logic is_reg, input logic [31:0] a,
                                          input logic [31:0] b);
        logic signed [31:0] sa;
        sa = $signed(a) >>> b[4:0];
        case (f3)
            3'd0: begin
                if (is_reg && b5) return a - b;
                return a + b;
            end
            3'd1: return a << b[4:0];
            3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: return (a < b) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd5: begin
                if (b5) return sa;
                return a >> b[4:0];
            end
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    // Expected writeback/redirect for one instruction
    function automatic exp_t model(input instr_t t);
        exp_t e;
        logic wr;
        logic slt;
        logic sltu;
        e = '0;
        wr = 1'b0;
        slt = $signed(t.rs1) < $signed(t.rs2);
        sltu = t.rs1 < t.rs2;
        e.rd_addr = t.rd;
        case (t.opc)
            7'h33: begin e.rd_data = arith(t.f3, t.b5, 1'b1, t.rs1, t.rs2); wr = 1'b1; end
            7'h13: begin e.rd_data = arith(t.f3, t.b5, 1'b0, t.rs1, t.imm); wr = 1'b1; end
            7'h37: begin e.rd_data = t.imm; wr = 1'b1; end
            7'h17: begin e.rd_data = t.pc + t.imm; wr = 1'b1; end
`ifdef ALU_ISSUE_BRANCH_EN
            7'h6f, 7'h67: begin
                e.rd_data = t.pc + 32'd4;
                wr = 1'b1;
                e.taken = 1'b1;
                e.chk_target = 1'b1;
                e.target = (t.opc == 7'h6f) ? t.pc + t.imm : (t.rs1 + t.imm) & 32'hFFFF_FFFE;
            end
            7'h63: begin
                e.chk_target = 1'b1;
                e.target = t.pc + t.imm;
                case (t.f3)
                    3'b000: begin e.rd_data = t.rs1 - t.rs2; e.taken = (t.rs1 == t.rs2); end
                    3'b001: begin e.rd_data = t.rs1 - t.rs2; e.taken = (t.rs1 != t.rs2); end
                    3'b100: begin e.rd_data = {31'd0, slt}; e.taken = slt; end
                    3'b101: begin e.rd_data = {31'd0, slt}; e.taken = !slt; end
                    3'b110: begin e.rd_data = {31'd0, sltu}; e.taken = sltu; end
                    3'b111: begin e.rd_data = {31'd0, sltu}; e.taken = !sltu; end
                    default: begin e.illegal = 1'b1; e.chk_target = 1'b0; end
                endcase
            end
`endif
            default: e.illegal = 1'b1;
        endcase
`ifndef ALU_ISSUE_BRANCH_EN
        e.chk_target = 1'b1;  // redirect outputs tied to zero
`endif
        e.rd_we = wr && !e.illegal && (t.rd != 5'd0);
        return e;
    endfunction

    function automatic instr_t mk(input logic [6:0] opc, input logic [2:0] f3, input logic b5,
                                  input logic [4:0] rd, input logic [31:0] rs1,
                                  input logic [31:0] rs2, input logic [31:0] imm,
                                  input logic [31:0] pc);
        instr_t t;
        t.opc = opc; t.f3 = f3; t.b5 = b5; t.rd = rd;
        t.rs1 = rs1; t.rs2 = rs2; t.imm = imm; t.pc = pc;
        return t;
    endfunction

    task automatic put(input instr_t t);
        bus.i_opcode = t.opc; bus.i_funct3 = t.f3; bus.i_funct7b5 = t.b5; bus.i_rd = t.rd;
        bus.i_rs1_val = t.rs1; bus.i_rs2_val = t.rs2; bus.i_imm = t.imm; bus.i_pc = t.pc;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (rdy_rand) bus.i_ready = ($urandom_range(0, 3) != 0);
    endtask

    // Present one instruction until accepted; expectation queued at the accepting cycle.
    task automatic send(input instr_t t, input logic chk_op, input logic [3:0] op_req,
                        output int waited);
        exp_t e;
        e = model(t);
        put(t);
        bus.i_valid = 1'b1;
        waited = 0;
        forever begin
            @(negedge clk);
            if (bus.o_ready) begin
                if (chk_op) check("alu_op", 32'(bus.o_alu_op), 32'(op_req));
                exp_q.push_back(e);
                step();
                break;
            end
            if (waited == 64) begin
                n_total++;
                $display("FAIL accept_timeout: got o_ready=0 for 64 cycles, expected accept");
                step();
                break;
            end
            waited++;
            step();
        end
        bus.i_valid = 1'b0;
    endtask

    // Monitor: compare each result as writeback takes it
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else if (bus.o_valid && bus.i_ready) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_output: got o_valid=1, expected no pending result");
            end else begin
                mon_e = exp_q.pop_front();
                check("rd_addr", 32'(bus.o_rd_addr), 32'(mon_e.rd_addr));
                check("rd_data", bus.o_rd_data, mon_e.rd_data);
                check("rd_we", 32'(bus.o_rd_we), 32'(mon_e.rd_we));
                check("illegal", 32'(bus.o_illegal), 32'(mon_e.illegal));
                check("br_taken", 32'(bus.o_br_taken), 32'(mon_e.taken));
                if (mon_e.chk_target) check("br_target", bus.o_br_target, mon_e.target);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish, expected bench completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        instr_t t;
        int w;
        int pick;
        logic [6:0] opcs [7];
        opcs = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h6f, 7'h67, 7'h63};

        rst = 1'b1;
        rdy_rand = 1'b0;
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b1;
        put(mk(7'h0, 3'd0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0));
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        @(negedge clk);
        check("rst_valid", 32'(bus.o_valid), 32'd0);
        check("rst_ready", 32'(bus.o_ready), 32'd1);
        check("rst_rd_data", bus.o_rd_data, 32'd0);
        check("rst_rd_we", 32'(bus.o_rd_we), 32'd0);
        check("rst_br_taken", 32'(bus.o_br_taken), 32'd0);
        check("rst_br_target", bus.o_br_target, 32'd0);
        check("rst_illegal", 32'(bus.o_illegal), 32'd0);
        step();

        // Directed cases
        send(mk(7'h33, 3'd0, 1'b0, 5'd3, 32'd5, 32'd7, 32'd0, 32'd0), 1'b1, 4'd0, w);
        send(mk(7'h13, 3'd5, 1'b1, 5'd6, 32'h8000_0000, 32'd0, 32'd4, 32'd0), 1'b1, 4'd7, w);
        send(mk(7'h63, 3'd0, 1'b0, 5'd1, 32'd9, 32'd9, 32'h20, 32'h100), 1'b0, 4'd0, w);
        send(mk(7'h63, 3'd1, 1'b0, 5'd1, 32'd9, 32'd9, 32'h20, 32'h100), 1'b0, 4'd0, w);
        send(mk(7'h6f, 3'd0, 1'b0, 5'd1, 32'd0, 32'd0, 32'h40, 32'h200), 1'b0, 4'd0, w);
        send(mk(7'h7f, 3'd0, 1'b0, 5'd5, 32'd3, 32'd4, 32'd8, 32'h300), 1'b1, 4'd0, w);
        send(mk(7'h33, 3'd0, 1'b1, 5'd0, 32'd20, 32'd8, 32'd0, 32'd0), 1'b1, 4'd1, w);
        step();
        step();

        // Backpressure: result 1+2 held for three cycles while the next one waits
        bus.i_ready = 1'b0;
        send(mk(7'h33, 3'd0, 1'b0, 5'd4, 32'd1, 32'd2, 32'd0, 32'd0), 1'b0, 4'd0, w);
        t = mk(7'h33, 3'd4, 1'b0, 5'd7, 32'hF0, 32'h0F, 32'd0, 32'd0);
        put(t);
        bus.i_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_ready", 32'(bus.o_ready), 32'd0);
            check("bp_valid", 32'(bus.o_valid), 32'd1);
            check("bp_rd_data", bus.o_rd_data, 32'd3);
            check("bp_rd_addr", 32'(bus.o_rd_addr), 32'd4);
            step();
        end
        bus.i_ready = 1'b1;
        send(t, 1'b0, 4'd0, w);
        check("bp_accept_wait", 32'(w), 32'd0);
        step();
        step();

        // Reset while a result is held: it is discarded
        bus.i_ready = 1'b0;
        send(mk(7'h37, 3'd0, 1'b0, 5'd9, 32'd0, 32'd0, 32'h1234_5000, 32'd0), 1'b0, 4'd0, w);
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        check("rst_hold_valid", 32'(bus.o_valid), 32'd0);
        check("rst_hold_rd_data", bus.o_rd_data, 32'd0);
        check("rst_hold_rd_we", 32'(bus.o_rd_we), 32'd0);
        step();
        bus.i_ready = 1'b1;

        // Randomized traffic with random writeback stalls
        rdy_rand = 1'b1;
        for (int n = 0; n < 400; n++) begin
            pick = $urandom_range(0, 8);
            if (pick < 7) t.opc = opcs[pick];
            else if (pick == 7) t.opc = 7'h7f;
            else t.opc = 7'($urandom);
            t.f3 = 3'($urandom);
            t.b5 = 1'($urandom);
            t.rd = 5'($urandom);
            t.rs1 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            t.rs2 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            if ($urandom_range(0, 4) == 0) t.rs2 = t.rs1;
            t.imm = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 63)) : $urandom;
            t.pc = $urandom & 32'hFFFF_FFFC;
            send(t, 1'b0, 4'd0, w);
        end

        rdy_rand = 1'b0;
        bus.i_ready = 1'b1;
        for (int n = 0; n < 20; n++) begin
            if (exp_q.size() == 0) break;
            step();
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
